// File: rtl/cpu_sequencer.sv
// cpu_sequencer: T-state microcode sequencer for the 8-bit bus CPU.
// Ports: clk, rst; opcode, cf, zf, run, step in; ctrl, t_state, instr_done, halted out.
module cpu_sequencer #(
  parameter logic [3:0] HLT_OPCODE = 4'hF,
  parameter bit         STEP_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        cf,
  input  logic        zf,
  input  logic        run,
  input  logic        step,
  output logic [14:0] ctrl,
  output logic [2:0]  t_state,
  output logic        instr_done,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_WAIT = 3'd6,
    S_HALT = 3'd7
  } state_e;

  localparam logic [14:0] IDLE = 15'h0FE3;

  // Asserting a line flips it away from its idle level,
  // so ctrl = IDLE ^ act for every line polarity.
  localparam logic [14:0] CP   = 15'h4000;
  localparam logic [14:0] EP   = 15'h2000;
  localparam logic [14:0] LP   = 15'h1000;
  localparam logic [14:0] NLMA = 15'h0800;
  localparam logic [14:0] NLMD = 15'h0400;
  localparam logic [14:0] NCE  = 15'h0200;
  localparam logic [14:0] NLR  = 15'h0100;
  localparam logic [14:0] NLI  = 15'h0080;
  localparam logic [14:0] NEI  = 15'h0040;
  localparam logic [14:0] NLA  = 15'h0020;
  localparam logic [14:0] EA   = 15'h0010;
  localparam logic [14:0] SUB  = 15'h0008;
  localparam logic [14:0] EU   = 15'h0004;
  localparam logic [14:0] NLB  = 15'h0002;
  localparam logic [14:0] NLO  = 15'h0001;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;

  state_e      state_q, state_d;
  logic        step_q;
  logic        pend_q, pend_d;
  logic        is_hlt;
  logic        last;
  logic        boundary;
  logic        start;
  logic        step_rise;
  logic        consume;
  logic [14:0] act;

  assign is_hlt = (opcode == HLT_OPCODE);

  always_comb begin
    last = 1'b0;
    unique case (state_q)
      S_T2: last = !is_hlt &&
                   !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA});
      S_T3: last = (opcode == OP_LDA);
      S_T4: last = 1'b1;
      default: last = 1'b0;
    endcase
  end

  always_comb begin
    act = '0;
    unique case (state_q)
      S_T0: act = EP | NLMA;
      S_T1: act = CP | NCE | NLI;
      S_T2: begin
        if (!is_hlt) begin
          case (opcode)
            OP_LDA, OP_ADD,
            OP_SUB, OP_STA: act = NEI | NLMA;
            OP_LDI:         act = NEI | NLA;
            OP_JMP:         act = NEI | LP;
            OP_JC:          act = cf ? (NEI | LP) : '0;
            OP_JZ:          act = zf ? (NEI | LP) : '0;
            OP_OUT:         act = EA | NLO;
            default:        act = '0;
          endcase
        end
      end
      S_T3: begin
        case (opcode)
          OP_LDA:         act = NCE | NLA;
          OP_ADD, OP_SUB: act = NCE | NLB;
          OP_STA:         act = EA | NLMD;
          default:        act = '0;
        endcase
      end
      S_T4: begin
        case (opcode)
          OP_ADD:  act = EU | NLA;
          OP_SUB:  act = EU | NLA | SUB;
          OP_STA:  act = NLR;
          default: act = '0;
        endcase
      end
      default: act = '0;
    endcase
    // Nothing is loaded on the reset edge.
    if (rst) act = '0;
  end

  always_comb begin
    step_rise = step && !step_q;
    boundary  = last || (state_q == S_WAIT);
    start     = !STEP_EN || run || pend_q;
    consume   = boundary && pend_q;
    // An edge in the consuming cycle re-arms pending.
    pend_d    = (pend_q && !consume) || step_rise;
    state_d   = state_q;
    unique case (state_q)
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = is_hlt ? S_HALT : S_T3;
      S_T3:    state_d = S_T4;
      default: state_d = state_q;
    endcase
    if (boundary) state_d = start ? S_T0 : S_WAIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STEP_EN ? S_WAIT : S_T0;
      step_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step;
      pend_q  <= pend_d;
    end
  end

  assign ctrl       = IDLE ^ act;
  assign t_state    = state_q;
  assign halted     = !rst && (state_q == S_HALT);
  assign instr_done = !rst &&
                      (last || (state_q == S_T2 && is_hlt));

endmodule
